// File: rtl/multiplier_pkg.sv
// Shared constants and types for the block multiplier and the multi-precision
// multiply scheduler (block width, default block count, scheduler FSM states).
package multiplier_pkg;

    localparam int BLOCK_LENGTH          = 16;
    localparam int MULT_SCHED_NUM_BLOCKS = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } mult_sched_state_e;

endpackage

// File: rtl/multiplier_16x16.sv
// Single-cycle registered BLOCK_LENGTH x BLOCK_LENGTH unsigned multiplier.
// The product register is deliberately unreset; consumers gate it with a valid flag.
module multiplier_16x16
    import multiplier_pkg::*;
(
    input  logic                        clk_i,
    input  logic [BLOCK_LENGTH-1:0]     a_i,
    input  logic [BLOCK_LENGTH-1:0]     b_i,
    output logic [2*BLOCK_LENGTH-1:0]   p_o
);

    localparam int PW = 2 * BLOCK_LENGTH;

    always_ff @(posedge clk_i) begin
        p_o <= PW'(a_i) * PW'(b_i);
    end

endmodule

// File: rtl/mult_scheduler.sv
// Multi-precision multiply: time-multiplexes one registered block multiplier over
// all block pairs and accumulates shifted partial products. Define
// MULT_SCHED_LOW_HALF_EN to compute only the low half (a*b mod 2^(NUM_BLOCKS*BLOCK_LENGTH)).
module mult_scheduler
    import multiplier_pkg::*;
#(
    parameter int NUM_BLOCKS = MULT_SCHED_NUM_BLOCKS
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [NUM_BLOCKS*BLOCK_LENGTH-1:0]  indata_a_i,
    input  logic [NUM_BLOCKS*BLOCK_LENGTH-1:0]  indata_b_i,
    output logic                                busy_o,
    output logic                                valid_o,
    output logic [2*NUM_BLOCKS*BLOCK_LENGTH-1:0] outdata_r_o
);

    localparam int OPW = NUM_BLOCKS * BLOCK_LENGTH;
    localparam int RW  = 2 * OPW;
    localparam int CW  = $clog2(NUM_BLOCKS);
    localparam int SW  = $clog2(2 * NUM_BLOCKS);

    mult_sched_state_e state_q, state_d;
    logic [OPW-1:0]    a_q, a_d, b_q, b_d;
    logic [CW-1:0]     i_q, i_d, j_q, j_d;
    logic [SW-1:0]     shift_q;
    logic              acc_en_q;
    logic [RW-1:0]     acc_q, acc_d;
    logic [RW-1:0]     out_q;
    logic              issue, acc_clr, j_last, pair_last;

    logic [BLOCK_LENGTH-1:0]   a_blk [NUM_BLOCKS];
    logic [BLOCK_LENGTH-1:0]   b_blk [NUM_BLOCKS];
    logic [2*BLOCK_LENGTH-1:0] prod;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_blk
            assign a_blk[gi] = a_q[gi*BLOCK_LENGTH +: BLOCK_LENGTH];
            assign b_blk[gi] = b_q[gi*BLOCK_LENGTH +: BLOCK_LENGTH];
        end
    endgenerate

    multiplier_16x16 u_mult (
        .clk_i (clk_i),
        .a_i   (a_blk[i_q]),
        .b_i   (b_blk[j_q]),
        .p_o   (prod)
    );

    // j is the inner loop; in low-half mode row i stops once i+j reaches NUM_BLOCKS-1.
`ifdef MULT_SCHED_LOW_HALF_EN
    assign j_last = (int'(i_q) + int'(j_q)) == (NUM_BLOCKS - 1);
`else
    assign j_last = int'(j_q) == (NUM_BLOCKS - 1);
`endif
    assign pair_last = j_last && (int'(i_q) == (NUM_BLOCKS - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        j_d     = j_q;
        issue   = 1'b0;
        acc_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = indata_a_i;
                    b_d     = indata_b_i;
                    i_d     = '0;
                    j_d     = '0;
                    acc_clr = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                issue = 1'b1;
                if (pair_last) begin
                    state_d = DRAIN;
                end else if (j_last) begin
                    i_d = i_q + CW'(1);
                    j_d = '0;
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // acc_en_q/shift_q travel one cycle behind the issue, matching the multiplier register.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (acc_en_q) begin
            acc_d = acc_q + (RW'(prod) << (int'(shift_q) * BLOCK_LENGTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            shift_q  <= '0;
            acc_en_q <= 1'b0;
            acc_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            i_q      <= i_d;
            j_q      <= j_d;
            shift_q  <= SW'(i_q) + SW'(j_q);
            acc_en_q <= issue;
            acc_q    <= acc_d;
            // Result register loads the final sum as DRAIN retires, so it is valid in DONE.
            if (state_q == DRAIN) begin
`ifdef MULT_SCHED_LOW_HALF_EN
                out_q <= {{OPW{1'b0}}, acc_d[OPW-1:0]};
`else
                out_q <= acc_d;
`endif
            end
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign valid_o     = (state_q == DONE);
    assign outdata_r_o = out_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Self-checking bench for mult_scheduler: directed and random operands against a
// plain-arithmetic product model, with cycle-exact busy/valid timing checks.
module tb_mult_scheduler;
    import multiplier_pkg::*;

    localparam int N   = MULT_SCHED_NUM_BLOCKS;
    localparam int OPW = N * BLOCK_LENGTH;
    localparam int RW  = 2 * OPW;
`ifdef MULT_SCHED_LOW_HALF_EN
    localparam bit LOW = 1'b1;
    localparam int P   = N * (N + 1) / 2;
`else
    localparam bit LOW = 1'b0;
    localparam int P   = N * N;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [OPW-1:0] a_in = '0;
    logic [OPW-1:0] b_in = '0;
    logic           busy, valid;
    logic [RW-1:0]  outdata;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    mult_scheduler #(.NUM_BLOCKS(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .indata_a_i  (a_in),
        .indata_b_i  (b_in),
        .busy_o      (busy),
        .valid_o     (valid),
        .outdata_r_o (outdata)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] model(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        logic [RW-1:0] full;
        full = RW'(a) * RW'(b);
        if (LOW) full[RW-1:OPW] = '0;
        return full;
    endfunction

    function automatic logic [OPW-1:0] rnd_op();
        return {$urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 200 && busy !== 1'b0; k++) tick();
        chk({tag, "_idle_timeout"}, RW'(busy), RW'(1'b0));
    endtask

    // Called in an IDLE cycle (t=0); checks busy/valid each cycle through t=P+3.
    task automatic run_op(input string tag, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        logic [RW-1:0] exp;
        exp   = model(a, b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        tick();
        start = 1'b0;
        a_in  = rnd_op();
        b_in  = rnd_op();
        for (int t = 1; t <= P + 2; t++) begin
            chk({tag, "_busy"}, RW'(busy), RW'(1'b1));
            chk({tag, "_valid"}, RW'(valid), RW'(t == P + 2));
            if (t == P + 2) chk({tag, "_data"}, outdata, exp);
            tick();
        end
        chk({tag, "_busy_after"}, RW'(busy), RW'(1'b0));
        chk({tag, "_valid_after"}, RW'(valid), RW'(1'b0));
        chk({tag, "_data_held"}, outdata, exp);
        $display("run %s a=%0h b=%0h result=%0h", tag, a, b, outdata);
    endtask

    initial begin
        logic [OPW-1:0] a0, b0;
        logic [RW-1:0]  e0;

        repeat (3) tick();
        rst = 1'b0;
        chk("reset_busy", RW'(busy), RW'(1'b0));
        chk("reset_valid", RW'(valid), RW'(1'b0));
        chk("reset_data", outdata, '0);

        run_op("all_ones", {OPW{1'b1}}, {OPW{1'b1}});
        if (LOW) chk("all_ones_const", outdata, RW'(1));
        else     chk("all_ones_const", outdata, {{(OPW-1){1'b1}}, 1'b0, {(OPW-1){1'b0}}, 1'b1});
        run_op("small", OPW'(3), OPW'(5));
        run_op("cross_block", OPW'(64'h0001_0000_0000_0000), OPW'(64'h0000_0000_0001_0000));
        run_op("zero_a", '0, OPW'(64'h1234_5678_9ABC_DEF0));

        // start held high: operand change at t=5 must not affect the first result.
        a0 = rnd_op();
        b0 = rnd_op();
        e0 = model(a0, b0);
        start = 1'b1;
        a_in  = a0;
        b_in  = b0;
        tick();
        for (int t = 1; t <= 40; t++) begin
            if (t == 5) begin
                a_in = '0;
                b_in = '0;
            end
            chk("hold_valid", RW'(valid), RW'((t == P + 2) || (t == 2 * P + 5)));
            if (t == P + 2) chk("hold_first_data", outdata, e0);
            if (t == 2 * P + 5) chk("hold_second_data", outdata, '0);
            tick();
        end
        start = 1'b0;
        wait_idle("hold");
        $display("run hold a=%0h b=%0h first=%0h", a0, b0, e0);

        // Reset in the middle of a run, then a clean small product.
        start = 1'b1;
        a_in  = rnd_op();
        b_in  = rnd_op();
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", RW'(busy), RW'(1'b0));
        chk("midrst_valid", RW'(valid), RW'(1'b0));
        chk("midrst_data", outdata, '0);
        $display("run mid_reset cleared busy=%0b valid=%0b data=%0h", busy, valid, outdata);
        run_op("after_rst", OPW'(2), OPW'(7));

        for (int k = 0; k < 12; k++) run_op("random", rnd_op(), rnd_op());
        run_op("random_max_a", {OPW{1'b1}}, rnd_op());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
